// File: rtl/cdr_pkg.sv
// cdr_pkg: shared definitions for the Mueller-Muller CDR acquisition logic.
//   - state encoding of the acquisition sequencer
//   - default PI gain shifts for acquisition and tracking
//   - phase-detector error width and its magnitude width
//   - abs_fn: exact |f_n| (the most negative input maps to +32768)
package cdr_pkg;

    localparam int FN_W    = 16;
    localparam int MAG_W   = 17;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACQ    = 3'd2,
        ST_TRACK  = 3'd3,
        ST_LOCKED = 3'd4
    } cdr_state_e;

    localparam logic [4:0] KP_ACQ_DEF = 5'd8;
    localparam logic [4:0] KI_ACQ_DEF = 5'd14;
    localparam logic [4:0] KP_TRK_DEF = 5'd12;
    localparam logic [4:0] KI_TRK_DEF = 5'd18;

    // Sign-extend by one bit first so that -32768 negates to +32768 without overflow.
    function automatic logic [MAG_W-1:0] abs_fn(input logic signed [FN_W-1:0] x);
        logic [MAG_W-1:0] xe;
        xe = {x[FN_W-1], x};
        return xe[MAG_W-1] ? (~xe + 1'b1) : xe;
    endfunction

endpackage

// File: rtl/cdr_err_window.sv
// cdr_err_window: windowed sum of |f_n| used for lock decisions.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   init        : holds accumulator and strobe counter at zero
//   run         : accumulate on sample_en strobes while high
//   sample_en   : symbol strobe
//   f_n         : signed phase-detector error
//   win_done    : combinational, high on the strobe that closes a window
//   win_good    : combinational, window sum (including the current sample)
//                 is below LOCK_THR; meaningful only with win_done
module cdr_err_window
    import cdr_pkg::*;
#(
    parameter int          LOCK_WIN = 256,
    parameter logic [31:0] LOCK_THR = 32'd65536
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    input  logic                   run,
    input  logic                   sample_en,
    input  logic signed [FN_W-1:0] f_n,
    output logic                   win_done,
    output logic                   win_good
);

    localparam int CNT_W = $clog2(LOCK_WIN + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      acc_q, acc_d;
    logic [32:0]      sum_wide;
    logic [31:0]      sum_sat;
    logic             strobe;
    logic             last;

    always_comb begin
        strobe   = run & sample_en;
        last     = (cnt_q == CNT_W'(LOCK_WIN - 1));
        sum_wide = {1'b0, acc_q} + {16'b0, abs_fn(f_n)};
        // Saturate at all-ones instead of wrapping back to a "good" value.
        sum_sat  = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
        win_done = strobe & last;
        win_good = (sum_sat < LOCK_THR);

        cnt_d = cnt_q;
        acc_d = acc_q;
        if (init) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (strobe) begin
            if (last) begin
                cnt_d = '0;
                acc_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = sum_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cdr_acq_ctrl.sv
// cdr_acq_ctrl: acquisition / lock sequencer for the baud-rate MM CDR loop.
// Sequence: IDLE -> CLEAR (1 cycle) -> ACQ (fast gains, ACQ_SYMS strobes)
//           -> TRACK (slow gains) -> LOCKED, with automatic re-acquisition
//           on track timeout, loss of lock or clamp saturation.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   enable     : run the sequencer (level); low forces IDLE
//   sample_en  : symbol strobe from the DCO
//   f_n        : signed PD error
//   clamp      : dfcw clamp active
//   kp_shift   : PI proportional shift
//   ki_shift   : PI integral shift
//   pi_clear   : clears the PI (high for the single CLEAR cycle)
//   pd_hold    : PI must not update (IDLE or CLEAR)
//   locked     : lock indication
//   lock_lost  : one-cycle pulse when LOCKED falls back to CLEAR
//   retries    : saturating count of CLEAR entries from TRACK/LOCKED
//   state      : current state encoding (debug)
module cdr_acq_ctrl
    import cdr_pkg::*;
#(
    parameter int          ACQ_SYMS      = 1024,
    parameter int          LOCK_WIN      = 256,
    parameter logic [31:0] LOCK_THR      = 32'd65536,
    parameter int          LOCK_GOOD     = 4,
    parameter int          UNLOCK_BAD    = 2,
    parameter int          TRACK_MAX_WIN = 64,
    parameter int          SAT_MAX       = 32,
    parameter logic [4:0]  KP_ACQ        = KP_ACQ_DEF,
    parameter logic [4:0]  KI_ACQ        = KI_ACQ_DEF,
    parameter logic [4:0]  KP_TRK        = KP_TRK_DEF,
    parameter logic [4:0]  KI_TRK        = KI_TRK_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   sample_en,
    input  logic signed [FN_W-1:0] f_n,
    input  logic                   clamp,
    output logic [4:0]             kp_shift,
    output logic [4:0]             ki_shift,
    output logic                   pi_clear,
    output logic                   pd_hold,
    output logic                   locked,
    output logic                   lock_lost,
    output logic [7:0]             retries,
    output logic [STATE_W-1:0]     state
);

    localparam int ACQ_W  = $clog2(ACQ_SYMS + 1);
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);
    localparam int TWIN_W = $clog2(TRACK_MAX_WIN + 1);
    localparam int SAT_W  = $clog2(SAT_MAX + 1);

    cdr_state_e        state_q, state_d;
    logic [ACQ_W-1:0]  acq_cnt_q, acq_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic [TWIN_W-1:0] twin_cnt_q, twin_cnt_d;
    logic [SAT_W-1:0]  sat_cnt_q, sat_cnt_d;
    logic [7:0]        retries_q, retries_d;
    logic              lock_lost_q, lock_lost_d;

    logic in_mon;
    logic win_done;
    logic win_good;
    logic sat_hit;

    assign in_mon = (state_q == ST_TRACK) || (state_q == ST_LOCKED);

    // The window monitor is held at zero outside TRACK/LOCKED, so it starts
    // fresh on every TRACK entry and runs on uninterrupted into LOCKED.
    cdr_err_window #(
        .LOCK_WIN (LOCK_WIN),
        .LOCK_THR (LOCK_THR)
    ) u_win (
        .clk       (clk),
        .rst       (rst),
        .init      (!in_mon),
        .run       (in_mon),
        .sample_en (sample_en),
        .f_n       (f_n),
        .win_done  (win_done),
        .win_good  (win_good)
    );

    always_comb begin
        state_d     = state_q;
        acq_cnt_d   = acq_cnt_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        twin_cnt_d  = twin_cnt_q;
        sat_cnt_d   = sat_cnt_q;
        retries_d   = retries_q;
        lock_lost_d = 1'b0;

        sat_hit = in_mon && sample_en && clamp && (sat_cnt_q == SAT_W'(SAT_MAX - 1));

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_CLEAR;
                ST_CLEAR: state_d = ST_ACQ;
                ST_ACQ: begin
                    if (sample_en) begin
                        if (acq_cnt_q == ACQ_W'(ACQ_SYMS - 1)) state_d = ST_TRACK;
                        else                                   acq_cnt_d = acq_cnt_q + 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (sample_en) sat_cnt_d = clamp ? sat_cnt_q + 1'b1 : '0;
                    if (win_done) begin
                        twin_cnt_d = twin_cnt_q + 1'b1;
                        good_cnt_d = win_good ? good_cnt_q + 1'b1 : '0;
                        if (win_good && (good_cnt_q == GOOD_W'(LOCK_GOOD - 1)))
                            state_d = ST_LOCKED;
                        else if (twin_cnt_q == TWIN_W'(TRACK_MAX_WIN - 1))
                            state_d = ST_CLEAR;
                    end
                    // Saturation overrides a lock decision on the same strobe.
                    if (sat_hit) state_d = ST_CLEAR;
                end
                ST_LOCKED: begin
                    if (sample_en) sat_cnt_d = clamp ? sat_cnt_q + 1'b1 : '0;
                    if (win_done) begin
                        if (win_good) begin
                            bad_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 1'b1;
                            if (bad_cnt_q == BAD_W'(UNLOCK_BAD - 1)) state_d = ST_CLEAR;
                        end
                    end
                    if (sat_hit) state_d = ST_CLEAR;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A CLEAR entry restarts every counter; coincident causes collapse
        // into one entry, hence one retry and at most one lock_lost pulse.
        if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) begin
            acq_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            twin_cnt_d = '0;
            sat_cnt_d  = '0;
            if (in_mon && (retries_q != 8'hFF)) retries_d = retries_q + 8'd1;
            lock_lost_d = (state_q == ST_LOCKED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acq_cnt_q   <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            twin_cnt_q  <= '0;
            sat_cnt_q   <= '0;
            retries_q   <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acq_cnt_q   <= acq_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            twin_cnt_q  <= twin_cnt_d;
            sat_cnt_q   <= sat_cnt_d;
            retries_q   <= retries_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign kp_shift  = in_mon ? KP_TRK : KP_ACQ;
    assign ki_shift  = in_mon ? KI_TRK : KI_ACQ;
    assign pd_hold   = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
    assign pi_clear  = (state_q == ST_CLEAR);
    assign locked    = (state_q == ST_LOCKED);
    assign lock_lost = lock_lost_q;
    assign retries   = retries_q;
    assign state     = state_q;

endmodule
